soc_system_sysid_checker: RTL and testbench
===========================================

# soc_system_sysid_checker

Avalon-MM read initiator that interrogates the system ID slave at boot or on request. Reads word 0 (system ID) then word 1 (build timestamp), captures both, and compares them against expected values set at build time. Sits on the Qsys fabric next to the sysid slave. Drives a pass/fail status that the HPS bridge or a front-panel LED can use to reject a mismatched FPGA image.

## Interface
Parameters:
- EXPECTED_ID, 32'hACD51302, expected word at address 0
- EXPECTED_TS, 32'h5913ED0B, expected word at address 1
- TIMEOUT_CYCLES, 255, maximum cycles per read (request plus response) before abort; legal range 1..65535

Ports:
- clock  in  1  system clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse; begins a check when idle
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when a check finishes (pass, fail or timeout)
- id_match  out  1  captured ID equals EXPECTED_ID
- ts_match  out  1  captured timestamp equals EXPECTED_TS
- timeout_err  out  1  a read exceeded TIMEOUT_CYCLES
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word
- avm_address  out  1  word address to slave
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data qualifier

## Operation
- States: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FIN.
- IDLE: start=1 clears id_match, ts_match, timeout_err, id_value and ts_value, then goes to ID_REQ. start is ignored in every other state.
- ID_REQ: avm_read=1, avm_address=0. The request is held stable until avm_waitrequest=0. Acceptance moves the FSM to ID_WAIT.
- ID_WAIT: avm_read=0. On avm_readdatavalid=1: capture id_value, set id_match, go to TS_REQ.
- TS_REQ and TS_WAIT: same as the ID states, with avm_address=1, capturing ts_value and setting ts_match. The response then moves the FSM to FIN.
- Zero-latency slaves: if avm_readdatavalid=1 in the same cycle the request is accepted, capture the data then and skip the WAIT state. ID_REQ goes directly to TS_REQ; TS_REQ goes directly to FIN.
- FIN: done=1 for exactly one cycle, then IDLE.
- Results (id_value, ts_value, id_match, ts_match, timeout_err) hold until the next accepted start.
- Timeout:
  - A 16-bit counter is cleared on entry to each REQ state and increments every cycle in REQ or WAIT.
  - If the counter reaches TIMEOUT_CYCLES with no response: avm_read drops, timeout_err=1, and the FSM goes to FIN.
  - Both match flags are forced to 0 on timeout.
  - The ID result is kept if the ID read completed.
- avm_readdatavalid outside the WAIT states, and outside REQ acceptance cycles, is ignored.
- Compare is full 32-bit equality; no masking.

## Timing
- Reset values: every output is 0; avm_address=0; FSM=IDLE; timeout counter=0.
- Reset asserted mid-operation: at the next edge avm_read=0, busy=0 and the FSM is IDLE. Any pending response is ignored.
- All outputs are registered.
- Start sampled at edge T:
  - busy=1 and avm_read=1 (address 0) from T+1.
  - With no wait states and read latency 1: ID response at T+2, TS request at T+3, TS response at T+4, done=1 at T+5, busy=0 at T+6.
- Each waitrequest cycle adds one cycle. Each extra latency cycle adds one cycle.
- Results are valid in the done cycle.
- start=1 in the done cycle is ignored. start=1 in the first IDLE cycle after done is accepted.

## Test plan
- Matching slave (0xACD51302 at address 0, 0x5913ED0B at address 1), latency 1, no waits, start at T → done at T+5; id_match=1, ts_match=1, timeout_err=0, id_value=0xACD51302.
- Slave returns 0x12345678 at address 1 → done; id_match=1, ts_match=0, ts_value=0x12345678.
- avm_waitrequest held 3 cycles on each request → avm_read and avm_address stable throughout; done at T+11; both matches 1.
- Slave never asserts readdatavalid for address 1, TIMEOUT_CYCLES=8 → avm_read low after 8 cycles in TS phase; timeout_err=1, both matches 0, id_value retained, done pulses once.
- Reset for 1 cycle while in TS_WAIT, with a response arriving the cycle after → all outputs 0, no done; a fresh start then completes normally.
- start pulsed while busy, plus stray readdatavalid in IDLE → no second check, no capture change, exactly one done per accepted start.

Source files
------------

// File: rtl/soc_system_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_sysid_checker
// Brief    : Avalon-MM initiator that reads the sysid ID and timestamp words
//            and compares them against build-time expected values.
// Revision : 1.0
// ============================================================================
module soc_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
  parameter logic [31:0] EXPECTED_TS    = 32'h5913ED0B,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  localparam logic [2:0] c_idle    = 3'd0;
  localparam logic [2:0] c_id_req  = 3'd1;
  localparam logic [2:0] c_id_wait = 3'd2;
  localparam logic [2:0] c_ts_req  = 3'd3;
  localparam logic [2:0] c_ts_wait = 3'd4;
  localparam logic [2:0] c_fin     = 3'd5;

  localparam logic [16:0] c_timeout = 17'(TIMEOUT_CYCLES);

  logic [2:0]  r_state;
  logic [15:0] r_cnt;

  logic        w_in_req;
  logic        w_in_wait;
  logic        w_ts_phase;
  logic        w_resp;
  logic        w_accept_only;
  logic [16:0] w_cnt_next;
  logic        w_expire;

  always_comb begin
    w_in_req      = (r_state == c_id_req) || (r_state == c_ts_req);
    w_in_wait     = (r_state == c_id_wait) || (r_state == c_ts_wait);
    w_ts_phase    = (r_state == c_ts_req) || (r_state == c_ts_wait);
    // A response is either a zero-latency completion on the accepting cycle
    // or read data arriving while parked in a WAIT state.
    w_resp        = (w_in_req && !avm_waitrequest && avm_readdatavalid) ||
                    (w_in_wait && avm_readdatavalid);
    w_accept_only = w_in_req && !avm_waitrequest && !avm_readdatavalid;
    w_cnt_next    = {1'b0, r_cnt} + 17'd1;
    w_expire      = (w_cnt_next >= c_timeout);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= c_idle;
      r_cnt       <= 16'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_match    <= 1'b0;
      ts_match    <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= 32'd0;
      ts_value    <= 32'd0;
      avm_address <= 1'b0;
      avm_read    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        c_idle: begin
          if (start) begin
            id_match    <= 1'b0;
            ts_match    <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
            busy        <= 1'b1;
            avm_read    <= 1'b1;
            avm_address <= 1'b0;
            r_cnt       <= 16'd0;
            r_state     <= c_id_req;
          end
        end

        c_id_req, c_id_wait, c_ts_req, c_ts_wait: begin
          r_cnt <= w_cnt_next[15:0];
          if (w_resp) begin
            if (!w_ts_phase) begin
              id_value    <= avm_readdata;
              id_match    <= (avm_readdata == EXPECTED_ID);
              avm_read    <= 1'b1;
              avm_address <= 1'b1;
              r_cnt       <= 16'd0;
              r_state     <= c_ts_req;
            end else begin
              ts_value <= avm_readdata;
              ts_match <= (avm_readdata == EXPECTED_TS);
              avm_read <= 1'b0;
              done     <= 1'b1;
              r_state  <= c_fin;
            end
          end else if (w_expire) begin
            // Abort takes priority over a bare acceptance so the read can never
            // slip into a WAIT state with an already-expired budget.
            avm_read    <= 1'b0;
            timeout_err <= 1'b1;
            id_match    <= 1'b0;
            ts_match    <= 1'b0;
            done        <= 1'b1;
            r_state     <= c_fin;
          end else if (w_accept_only) begin
            avm_read <= 1'b0;
            r_state  <= w_ts_phase ? c_ts_wait : c_id_wait;
          end
        end

        c_fin: begin
          busy        <= 1'b0;
          avm_address <= 1'b0;
          r_state     <= c_idle;
        end

        default: begin
          busy     <= 1'b0;
          avm_read <= 1'b0;
          r_state  <= c_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_soc_system_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_system_sysid_checker
// Brief    : Directed bench for soc_system_sysid_checker with a behavioural
//            Avalon-MM sysid slave (configurable waits, latency, stalls).
// Revision : 1.0
// ============================================================================
module tb_soc_system_sysid_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic        id_match;
  logic        ts_match;
  logic        timeout_err;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest   = 1'b0;
  logic [31:0] avm_readdata      = 32'd0;
  logic        avm_readdatavalid = 1'b0;

  soc_system_sysid_checker #(
    .EXPECTED_ID   (32'hACD51302),
    .EXPECTED_TS   (32'h5913ED0B),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .id_match         (id_match),
    .ts_match         (ts_match),
    .timeout_err      (timeout_err),
    .id_value         (id_value),
    .ts_value         (ts_value),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clock = ~clock;

  // Slave configuration
  int          s_waits   = 0;
  int          s_lat     = 1;
  bit          s_mute_ts = 1'b0;
  bit          s_stray   = 1'b0;
  logic [31:0] s_id      = 32'hACD51302;
  logic [31:0] s_ts      = 32'h5913ED0B;

  int          wcnt       = 0;
  bit          pend       = 1'b0;
  int          pdly       = 0;
  logic [31:0] pdata      = 32'd0;
  bit          prev_stall = 1'b0;
  logic        prev_addr  = 1'b0;
  int          hold_viol  = 0;
  int          done_cnt   = 0;

  // Slave drives its outputs on the falling edge so the DUT sees them settled.
  always @(negedge clock) begin
    if (prev_stall && !s_mute_ts && (avm_read !== 1'b1 || avm_address !== prev_addr))
      hold_viol++;
    if (done === 1'b1) done_cnt++;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'd0;
    avm_waitrequest   = 1'b0;
    if (pend) begin
      pdly--;
      if (pdly == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = pdata;
        pend              = 1'b0;
      end
    end
    if (s_stray) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = 32'hDEADBEEF;
    end
    if (avm_read === 1'b1 && !pend) begin
      if (s_mute_ts && avm_address === 1'b1) begin
        avm_waitrequest = 1'b1;
      end else if (wcnt < s_waits) begin
        avm_waitrequest = 1'b1;
        wcnt++;
      end else begin
        wcnt = 0;
        if (s_lat == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = avm_address ? s_ts : s_id;
        end else begin
          pend  = 1'b1;
          pdly  = s_lat;
          pdata = avm_address ? s_ts : s_id;
        end
      end
    end
    prev_stall = (avm_read === 1'b1) && avm_waitrequest;
    prev_addr  = avm_address;
  end

  int n_cmp = 0;
  int n_err = 0;
  int ts_cycles = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; start is sampled at the next rising edge (T).
  // kd is the index of the edge after T at which done is first sampled high.
  task automatic run_check(input bit again, input bit at_done, output int kd,
                           output logic busy1, output logic busy_after);
    start     = 1'b1;
    kd        = -1;
    busy1     = 1'b0;
    ts_cycles = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      start = again && (k == 2);
      if (k == 1) busy1 = busy;
      if (avm_read === 1'b1 && avm_address === 1'b1) ts_cycles++;
      if (done === 1'b1) begin
        kd = k;
        break;
      end
    end
    start = at_done;
    @(negedge clock);
    start      = 1'b0;
    busy_after = busy;
  endtask

  int   kd;
  int   dc0;
  logic b1;
  logic ba;

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_flags", {29'd0, id_match, ts_match, timeout_err}, 32'd0);
    check("rst_id_value", id_value, 32'd0);
    check("rst_ts_value", ts_value, 32'd0);
    check("rst_avm", {30'd0, avm_read, avm_address}, 32'd0);

    // Matching slave, latency 1, no waits
    run_check(1'b0, 1'b0, kd, b1, ba);
    check("match_done_cycle", 32'(kd), 32'd5);
    check("match_busy_t1", {31'd0, b1}, 32'd1);
    check("match_busy_after", {31'd0, ba}, 32'd0);
    check("match_flags", {29'd0, id_match, ts_match, timeout_err}, 32'b110);
    check("match_id_value", id_value, 32'hACD51302);
    check("match_ts_value", ts_value, 32'h5913ED0B);

    // Wrong timestamp
    s_ts = 32'h12345678;
    run_check(1'b0, 1'b0, kd, b1, ba);
    check("badts_done_cycle", 32'(kd), 32'd5);
    check("badts_flags", {29'd0, id_match, ts_match, timeout_err}, 32'b100);
    check("badts_ts_value", ts_value, 32'h12345678);
    s_ts = 32'h5913ED0B;

    // Three wait states on each request
    s_waits = 3;
    run_check(1'b0, 1'b0, kd, b1, ba);
    check("wait_done_cycle", 32'(kd), 32'd11);
    check("wait_flags", {29'd0, id_match, ts_match, timeout_err}, 32'b110);
    #1;
    check("wait_hold_stable", 32'(hold_viol), 32'd0);
    s_waits = 0;

    // Zero-latency slave skips both WAIT states
    s_lat = 0;
    run_check(1'b0, 1'b0, kd, b1, ba);
    check("zlat_done_cycle", 32'(kd), 32'd3);
    check("zlat_flags", {29'd0, id_match, ts_match, timeout_err}, 32'b110);
    s_lat = 1;

    // Timestamp read stalls forever: timeout after 8 cycles in TS phase
    s_mute_ts = 1'b1;
    #1 dc0 = done_cnt;
    run_check(1'b0, 1'b0, kd, b1, ba);
    check("tmo_done_cycle", 32'(kd), 32'd11);
    check("tmo_ts_read_cycles", 32'(ts_cycles), 32'd8);
    check("tmo_flags", {29'd0, id_match, ts_match, timeout_err}, 32'b001);
    check("tmo_id_value", id_value, 32'hACD51302);
    check("tmo_ts_value", ts_value, 32'd0);
    check("tmo_avm_read", {31'd0, avm_read}, 32'd0);
    repeat (3) @(negedge clock);
    #1;
    check("tmo_done_count", 32'(done_cnt - dc0), 32'd1);
    s_mute_ts = 1'b0;
    @(negedge clock);

    // Reset while in TS_WAIT with the response arriving one cycle later
    s_lat = 2;
    #1 dc0 = done_cnt;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_busy_read", {30'd0, busy, avm_read}, 32'd0);
    check("midrst_flags", {28'd0, done, id_match, ts_match, timeout_err}, 32'd0);
    check("midrst_id_value", id_value, 32'd0);
    repeat (4) @(negedge clock);
    #1;
    check("midrst_ignored_resp", {id_value[15:0], ts_value[15:0]}, 32'd0);
    check("midrst_no_done", 32'(done_cnt - dc0), 32'd0);
    s_lat = 1;
    @(negedge clock);
    run_check(1'b0, 1'b0, kd, b1, ba);
    check("midrst_rerun_cycle", 32'(kd), 32'd5);
    check("midrst_rerun_flags", {29'd0, id_match, ts_match, timeout_err}, 32'b110);

    // start while busy and in the done cycle, then stray readdatavalid in IDLE
    #1 dc0 = done_cnt;
    run_check(1'b1, 1'b1, kd, b1, ba);
    check("busy_start_cycle", 32'(kd), 32'd5);
    check("done_start_ignored", {31'd0, ba}, 32'd0);
    repeat (6) @(negedge clock);
    #1;
    check("one_done_per_start", 32'(done_cnt - dc0), 32'd1);
    @(negedge clock);
    s_stray = 1'b1;
    repeat (3) @(negedge clock);
    s_stray = 1'b0;
    repeat (2) @(negedge clock);
    check("stray_id_value", id_value, 32'hACD51302);
    check("stray_ts_value", ts_value, 32'h5913ED0B);
    check("stray_idle", {30'd0, busy, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
